// File: rtl/axi_mem_arbiter.sv
// Round-robin arbiter sharing one axi_master port between I-cache and D-cache.
// One transaction in flight; grant locked from IDLE until the DONE cycle ends.
module axi_mem_arbiter #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int DATA_WIDTH     = 512,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_ic_req,
    input  logic [AXI_ADDR_WIDTH-1:0] i_ic_addr,
    output logic                      o_ic_done,
    input  logic                      i_dc_req,
    input  logic                      i_dc_we,
    input  logic [AXI_ADDR_WIDTH-1:0] i_dc_addr,
    input  logic [DATA_WIDTH-1:0]     i_dc_wdata,
    output logic                      o_dc_done,
    output logic [DATA_WIDTH-1:0]     o_rd_data,
    output logic [1:0]                o_grant,
    output logic                      o_busy,
    output logic                      o_timeout,
    output logic [AXI_ADDR_WIDTH-1:0] o_axi_addr,
    output logic [DATA_WIDTH-1:0]     o_axi_data,
    output logic                      o_axi_start_read,
    output logic                      o_axi_start_write,
    input  logic [DATA_WIDTH-1:0]     i_axi_data,
    input  logic                      i_axi_read_last,
    input  logic                      i_axi_b_resp
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    // Compared one early so the registered flag is visible in busy cycle TIMEOUT_CYCLES
    localparam logic [15:0] LP_TO_M2 = 16'(TIMEOUT_CYCLES - 2);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_ptr_dc;
    logic                      r_we;
    logic [1:0]                r_grant;
    logic                      r_busy;
    logic                      r_timeout;
    logic [15:0]               r_cnt;
    logic                      r_ic_done;
    logic                      r_dc_done;
    logic                      r_start_read;
    logic                      r_start_write;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [DATA_WIDTH-1:0]     r_rd_data;
    logic                      w_req_any;
    logic                      w_pick_ic;
    logic                      w_pick_dc;
    logic                      w_cpl;

    assign w_req_any = i_ic_req | i_dc_req;
    assign w_pick_ic = i_ic_req & (~i_dc_req | ~r_ptr_dc);
    assign w_pick_dc = i_dc_req & ~w_pick_ic;
    assign w_cpl     = r_we ? i_axi_b_resp : i_axi_read_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_req_any) w_state_nxt = S_BUSY;
            S_BUSY:  if (w_cpl) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr_dc      <= 1'b0;
            r_we          <= 1'b0;
            r_grant       <= 2'b00;
            r_busy        <= 1'b0;
            r_timeout     <= 1'b0;
            r_cnt         <= 16'd0;
            r_ic_done     <= 1'b0;
            r_dc_done     <= 1'b0;
            r_start_read  <= 1'b0;
            r_start_write <= 1'b0;
            r_addr        <= '0;
            r_data        <= '0;
            r_rd_data     <= '0;
        end else begin
            r_ic_done <= 1'b0;
            r_dc_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_pick_ic) begin
                        r_grant      <= 2'b01;
                        r_busy       <= 1'b1;
                        r_addr       <= i_ic_addr;
                        r_data       <= '0;
                        r_we         <= 1'b0;
                        r_start_read <= 1'b1;
                        r_cnt        <= 16'd0;
                    end else if (w_pick_dc) begin
                        r_grant       <= 2'b10;
                        r_busy        <= 1'b1;
                        r_addr        <= i_dc_addr;
                        r_data        <= i_dc_wdata;
                        r_we          <= i_dc_we;
                        r_start_read  <= ~i_dc_we;
                        r_start_write <= i_dc_we;
                        r_cnt         <= 16'd0;
                    end
                end
                S_BUSY: begin
                    if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
                    if (r_cnt == LP_TO_M2) r_timeout <= 1'b1;
                    if (w_cpl) begin
                        r_start_read  <= 1'b0;
                        r_start_write <= 1'b0;
                        r_ic_done     <= r_grant[0];
                        r_dc_done     <= r_grant[1];
                        if (!r_we) r_rd_data <= i_axi_data;
                    end
                end
                S_DONE: begin
                    // Reloaded on exit too; the master holds its line through DONE
                    if (!r_we) r_rd_data <= i_axi_data;
                    r_ptr_dc <= r_grant[0];
                    r_grant  <= 2'b00;
                    r_busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_ic_done         = r_ic_done;
    assign o_dc_done         = r_dc_done;
    assign o_rd_data         = r_rd_data;
    assign o_grant           = r_grant;
    assign o_busy            = r_busy;
    assign o_timeout         = r_timeout;
    assign o_axi_addr        = r_addr;
    assign o_axi_data        = r_data;
    assign o_axi_start_read  = r_start_read;
    assign o_axi_start_write = r_start_write;

endmodule
